// File: rtl/config_uart_streamer_pkg.sv
// Shared types and constants for the config-ROM to UART byte streamer.
package config_uart_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TRIG,
    WAIT_HI,
    WAIT_LO
  } state_e;

  localparam int BYTES_PER_WORD  = 4;
  localparam int TX_FRAME_CYCLES = 91;

endpackage

// File: rtl/config_uart_streamer.sv
// Streams config words 0..NUM_WORDS-1 to the UART TX as 4 bytes each, LSB first,
// pacing every byte off the transmitter's busy flag (send, see busy rise, see it fall).
module config_uart_streamer
  import config_uart_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WORDS  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [31:0]           mem_readdata,
  input  logic                  tx_bsy,
  output logic                  send_trig,
  output logic [7:0]            send_data,
  output logic                  busy,
  output logic                  done
);

  localparam int             CNT_W    = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [1:0]     LAST_IDX = 2'(BYTES_PER_WORD - 1);

  state_e                state_q;
  logic [31:0]           word_q;
  logic [1:0]            idx_q;
  logic [1:0]            idx_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            data_q;
  logic                  busy_q;
  logic                  done_q;

  assign idx_d = idx_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done_q) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          word_q  <= mem_readdata;
          idx_q   <= '0;
          data_q  <= mem_readdata[7:0];
          state_q <= TRIG;
        end
        TRIG: begin
          if (!tx_bsy) state_q <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_bsy) state_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_bsy) begin
            if (idx_q != LAST_IDX) begin
              // Next byte is loaded on entry to TRIG so it is stable for the whole frame.
              idx_q   <= idx_d;
              data_q  <= word_q[{idx_d, 3'b000} +: 8];
              state_q <= TRIG;
            end else if (cnt_q == LAST_WORD) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              addr_q  <= addr_q + 1'b1;
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The strobe must land in the TRIG cycle that sees the transmitter idle.
  assign send_trig   = (state_q == TRIG) && !tx_bsy;
  assign send_data   = data_q;
  assign mem_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
